// File: rtl/udp_stream_mux_pkg.sv
// Shared types and constants for the UDP stream multiplexer.
package udp_stream_mux_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      DRAIN,
      GAP
   } state_t;

   localparam logic [7:0] HDR_MAGIC = 8'hC0;
   localparam int         SRC_ID_W  = 8;

   // Index width that stays legal (>= 1 bit) for a single source.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/udp_stream_mux_rr_arbiter.sv
// Combinational round-robin grant: first requester searching upward from last_grant+1.
module rr_arbiter
   import udp_stream_mux_pkg::*;
#(
   parameter int NUM_SRC = 3,
   localparam int IDX_W  = idx_width(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic               grant_valid,
   output logic [IDX_W-1:0]   grant_idx
);

   // NOTE: every output gets a default before the search so no latch is inferred.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      // Walk from the farthest candidate down so the nearest requester wins last.
      for (int k = NUM_SRC; k >= 1; k--) begin
         if (req[(int'(last_grant) + k) % NUM_SRC]) begin
            grant_valid = 1'b1;
            grant_idx   = IDX_W'((int'(last_grant) + k) % NUM_SRC);
         end
      end
   end

endmodule

// File: rtl/udp_stream_mux.sv
// Packet-level round-robin merge of NUM_SRC AXI streams into the UDP TX client port.
// Define UDP_STREAM_MUX_HDR_EN to prefix every frame with a source/sequence header word.
module udp_stream_mux
   import udp_stream_mux_pkg::*;
#(
   parameter int NUM_SRC   = 3,
   parameter int MAX_WORDS = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ena,
   input  logic [NUM_SRC-1:0]      src_mask,
   input  logic [NUM_SRC*64-1:0]   in_tdata,
   input  logic [NUM_SRC-1:0]      in_tvalid,
   input  logic [NUM_SRC-1:0]      in_tlast,
   output logic [NUM_SRC-1:0]      in_tready,
   input  logic                    udp_tx_cts,
   output logic [63:0]             udp_tx_data,
   output logic [7:0]              udp_tx_data_valid,
   output logic                    udp_tx_sof,
   output logic                    udp_tx_eof,
   output logic                    busy,
   output logic [31:0]             pkt_count,
   output logic [15:0]             trunc_count
);

   localparam int          IDX_W     = idx_width(NUM_SRC);
   localparam logic [15:0] LAST_WORD = 16'(MAX_WORDS - 1);
`ifdef UDP_STREAM_MUX_HDR_EN
   localparam bit          HDR_EN    = 1'b1;
`else
   localparam bit          HDR_EN    = 1'b0;
`endif

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     grant_q, last_grant_q, arb_idx;
   logic                 arb_valid;
   logic [NUM_SRC-1:0]   req, gnt_oh;
   logic [15:0]          word_cnt_q;
   logic [63:0]          cur_data;
   logic                 cur_valid, cur_last, accept, at_max;
`ifdef UDP_STREAM_MUX_HDR_EN
   logic [31:0]          seq_q;
`endif

   assign req  = in_tvalid & ~src_mask;
   assign busy = (state_q != IDLE);

   rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
      .req         (req),
      .last_grant  (last_grant_q),
      .grant_valid (arb_valid),
      .grant_idx   (arb_idx)
   );

   // Select the granted source's stream signals.
   always_comb begin
      cur_data  = '0;
      cur_valid = 1'b0;
      cur_last  = 1'b0;
      gnt_oh    = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_q == IDX_W'(i)) begin
            gnt_oh[i] = 1'b1;
            cur_data  = in_tdata[i*64 +: 64];
            cur_valid = in_tvalid[i];
            cur_last  = in_tlast[i];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      in_tready = '0;
      accept    = 1'b0;
      at_max    = (word_cnt_q == LAST_WORD);
      unique case (state_q)
         IDLE: begin
            if (ena && arb_valid) state_d = HDR_EN ? HDR : DATA;
         end
`ifdef UDP_STREAM_MUX_HDR_EN
         HDR: begin
            if (udp_tx_cts) state_d = DATA;
         end
`endif
         DATA: begin
            in_tready = gnt_oh & {NUM_SRC{udp_tx_cts}};
            accept    = cur_valid & udp_tx_cts;
            if (accept) begin
               if (cur_last)    state_d = GAP;
               else if (at_max) state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Discard the tail of a truncated packet without waiting on the UDP core.
            in_tready = gnt_oh;
            accept    = cur_valid;
            if (accept && cur_last) state_d = GAP;
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= IDLE;
         grant_q           <= '0;
         last_grant_q      <= IDX_W'(NUM_SRC - 1);
         word_cnt_q        <= '0;
         pkt_count         <= '0;
         trunc_count       <= '0;
         udp_tx_data       <= '0;
         udp_tx_data_valid <= '0;
         udp_tx_sof        <= 1'b0;
         udp_tx_eof        <= 1'b0;
      end else begin
         state_q           <= state_d;
         udp_tx_data       <= '0;
         udp_tx_data_valid <= '0;
         udp_tx_sof        <= 1'b0;
         udp_tx_eof        <= 1'b0;
         case (state_q)
            IDLE: begin
               word_cnt_q <= '0;
               grant_q    <= arb_idx;
            end
`ifdef UDP_STREAM_MUX_HDR_EN
            HDR: begin
               if (udp_tx_cts) begin
                  udp_tx_data       <= {HDR_MAGIC, SRC_ID_W'(grant_q), 16'h0000, seq_q};
                  udp_tx_data_valid <= 8'hFF;
                  udp_tx_sof        <= 1'b1;
               end
            end
`endif
            DATA: begin
               if (accept) begin
                  udp_tx_data       <= cur_data;
                  udp_tx_data_valid <= 8'hFF;
                  udp_tx_sof        <= !HDR_EN && (word_cnt_q == 16'd0);
                  udp_tx_eof        <= cur_last | at_max;
                  word_cnt_q        <= word_cnt_q + 16'd1;
                  if (at_max && !cur_last && trunc_count != 16'hFFFF)
                     trunc_count <= trunc_count + 16'd1;
               end
            end
            GAP: begin
               pkt_count    <= pkt_count + 32'd1;
               last_grant_q <= grant_q;
            end
            default: ;
         endcase
      end
   end

`ifdef UDP_STREAM_MUX_HDR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         seq_q <= '0;
      else if (state_q == HDR && udp_tx_cts) seq_q <= seq_q + 32'd1;
   end
`endif

endmodule
